// File: rtl/lpc_sniffer_pkg.sv
// ============================================================================
// Module      : lpc_sniffer_pkg
// Description : Shared record layout, marker encoding and arbiter state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lpc_sniffer_pkg;

    // Record field positions (48-bit record)
    localparam int c_REC_W       = 48;
    localparam int c_PAYLOAD_LSB = 16;
    localparam int c_SEQ_LSB     = 8;
    localparam int c_SUB_LSB     = 5;
    localparam int c_TIMEOUT_BIT = 4;

    localparam logic [3:0] c_MARKER_CODE = 4'hF;
    localparam logic [2:0] c_SUB_DROP    = 3'b001;
    localparam logic [2:0] c_SUB_HB      = 3'b010;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DROP  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    function automatic logic [c_REC_W-1:0] make_marker(
        input logic [2:0]  sub,
        input logic [7:0]  seq,
        input logic [31:0] payload
    );
        logic [c_REC_W-1:0] rec;
        rec = '0;
        rec[c_REC_W-1:c_PAYLOAD_LSB]    = payload;
        rec[c_SEQ_LSB+7:c_SEQ_LSB]      = seq;
        rec[c_SUB_LSB+2:c_SUB_LSB]      = sub;
        rec[c_TIMEOUT_BIT]              = 1'b0;
        rec[3:0]                        = c_MARKER_CODE;
        return rec;
    endfunction

endpackage

`default_nettype wire

// File: rtl/heartbeat_timer.sv
// ============================================================================
// Module      : heartbeat_timer
// Description : Free-running period timer; strobes expire and counts expiries.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module heartbeat_timer #(
    parameter int HB_CYCLES = 48000000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        expire,
    output logic [31:0] count
);

    generate
        if (HB_CYCLES > 0) begin : g_enabled
            localparam logic [31:0] c_LAST = 32'(HB_CYCLES - 1);

            logic [31:0] tick_q, tick_d;
            logic [31:0] count_q, count_d;
            logic        w_expire;

            always_comb begin
                w_expire = (tick_q == c_LAST);
                tick_d   = w_expire ? 32'd0 : tick_q + 32'd1;
                count_d  = w_expire ? count_q + 32'd1 : count_q;
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    tick_q  <= 32'd0;
                    count_q <= 32'd0;
                end else begin
                    tick_q  <= tick_d;
                    count_q <= count_d;
                end
            end

            assign expire = w_expire;
            assign count  = count_q;
        end else begin : g_disabled
            assign expire = 1'b0;
            assign count  = 32'd0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/record_arbiter.sv
// ============================================================================
// Module      : record_arbiter
// Description : Merges LPC records, drop markers and heartbeats into one
//               ring-buffer write stream with registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module record_arbiter
    import lpc_sniffer_pkg::*;
#(
    parameter int DW        = 48,
    parameter int HB_CYCLES = 48000000
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [DW-1:0] lpc_data,
    input  logic          lpc_enable,
    input  logic          buffer_full,
    output logic [DW-1:0] write_data,
    output logic          write_clock_enable,
    output logic [15:0]   drop_count,
    output logic          dropping
);

    state_t        state_q, state_d;
    logic [15:0]   drop_count_q, drop_count_d;
    logic [DW-1:0] hold_q, hold_d;
    logic [7:0]    seq_q, seq_d;
    logic          hb_pending_q, hb_pending_d;
    logic [DW-1:0] write_data_q, write_data_d;
    logic          wce_q, wce_d;

    logic          w_expire;
    logic [31:0]   w_hb_count;
    logic          w_hb_write;
    logic [15:0]   w_drop_inc;

    heartbeat_timer #(.HB_CYCLES(HB_CYCLES)) u_hb (
        .clock  (clock),
        .reset  (reset),
        .expire (w_expire),
        .count  (w_hb_count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_RUN;
            drop_count_q <= 16'd0;
            hold_q       <= '0;
            seq_q        <= 8'd0;
            hb_pending_q <= 1'b0;
            write_data_q <= '0;
            wce_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            drop_count_q <= drop_count_d;
            hold_q       <= hold_d;
            seq_q        <= seq_d;
            hb_pending_q <= hb_pending_d;
            write_data_q <= write_data_d;
            wce_q        <= wce_d;
        end
    end

    // FLUSH leaves to DROP whenever a record was lost while the hold drained
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (lpc_enable && buffer_full) state_d = ST_DROP;
            ST_DROP:  if (!buffer_full) state_d = lpc_enable ? ST_FLUSH : ST_RUN;
            ST_FLUSH: if (!buffer_full)
                          state_d = (lpc_enable || drop_count_q != 16'd0) ? ST_DROP : ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    assign w_drop_inc = (drop_count_q == 16'hFFFF) ? 16'hFFFF : drop_count_q + 16'd1;

    always_comb begin
        wce_d        = 1'b0;
        write_data_d = write_data_q;
        drop_count_d = drop_count_q;
        hold_d       = hold_q;
        seq_d        = seq_q;
        w_hb_write   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (lpc_enable) begin
                    if (!buffer_full) begin
                        wce_d        = 1'b1;
                        write_data_d = lpc_data;
                    end else begin
                        drop_count_d = 16'd1;
                    end
                end else if (!buffer_full && hb_pending_q) begin
                    wce_d        = 1'b1;
                    write_data_d = DW'(make_marker(c_SUB_HB, seq_q, w_hb_count));
                    seq_d        = seq_q + 8'd1;
                    w_hb_write   = 1'b1;
                end
            end
            ST_DROP: begin
                if (!buffer_full) begin
                    wce_d        = 1'b1;
                    write_data_d = DW'(make_marker(c_SUB_DROP, seq_q, {16'd0, drop_count_q}));
                    seq_d        = seq_q + 8'd1;
                    drop_count_d = 16'd0;
                    if (lpc_enable) hold_d = lpc_data;
                end else if (lpc_enable) begin
                    drop_count_d = w_drop_inc;
                end
            end
            ST_FLUSH: begin
                if (!buffer_full) begin
                    wce_d        = 1'b1;
                    write_data_d = hold_q;
                end
                if (lpc_enable) drop_count_d = w_drop_inc;
            end
            default: ;
        endcase
    end

    // Expiries arriving while a heartbeat is still owed collapse into one marker
    assign hb_pending_d = (hb_pending_q && !w_hb_write) || w_expire;

    assign write_data         = write_data_q;
    assign write_clock_enable = wce_q;
    assign drop_count         = drop_count_q;
    assign dropping           = (state_q != ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_record_arbiter.sv
// ============================================================================
// Module      : tb_record_arbiter
// Description : Randomized scoreboard bench for record_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_record_arbiter;

    localparam int DW = 48;
    localparam int HB = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] lpc_data = '0;
    logic          lpc_enable = 1'b0;
    logic          buffer_full = 1'b0;
    logic [DW-1:0] write_data;
    logic          write_clock_enable;
    logic [15:0]   drop_count;
    logic          dropping;

    record_arbiter #(.DW(DW), .HB_CYCLES(HB)) dut (
        .clock              (clock),
        .reset              (reset),
        .lpc_data           (lpc_data),
        .lpc_enable         (lpc_enable),
        .buffer_full        (buffer_full),
        .write_data         (write_data),
        .write_clock_enable (write_clock_enable),
        .drop_count         (drop_count),
        .dropping           (dropping)
    );

    always #5 clock = ~clock;

    int            total = 0;
    int            bad   = 0;
    logic [47:0]   exp_q[$];
    logic [47:0]   last_write = '0;

    // Reference model: pending drops, a held-record queue and heartbeat bookkeeping
    logic [47:0]   m_held[$];
    int            m_drops = 0;
    int            m_tick = 0;
    logic [31:0]   m_hbcnt = 0;
    logic          m_pend = 1'b0;
    logic [7:0]    m_seq = 0;
    int            exp_dc = 0;
    logic          exp_dropping = 1'b0;
    logic          after_reset = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] marker(input logic [2:0] sub, input logic [7:0] seq,
                                           input logic [31:0] payload);
        return {payload, seq, sub, 1'b0, 4'hF};
    endfunction

    function automatic int sat_inc(input int v);
        return (v < 65535) ? v + 1 : 65535;
    endfunction

    task automatic model_reset();
        m_held.delete();
        m_drops = 0; m_tick = 0; m_hbcnt = 0; m_pend = 1'b0; m_seq = 0;
        exp_dc = 0; exp_dropping = 1'b0;
    endtask

    task automatic model_step(input bit en, input bit full, input logic [47:0] d);
        bit hb_wrote = 0;
        bit expire;
        if (m_held.size() > 0) begin
            if (!full) exp_q.push_back(m_held.pop_front());
            if (en) m_drops = sat_inc(m_drops);
        end else if (m_drops > 0) begin
            if (!full) begin
                exp_q.push_back(marker(3'b001, m_seq, 32'(m_drops)));
                m_seq++;
                m_drops = 0;
                if (en) m_held.push_back(d);
            end else if (en) begin
                m_drops = sat_inc(m_drops);
            end
        end else if (en) begin
            if (!full) exp_q.push_back(d);
            else m_drops = 1;
        end else if (!full && m_pend) begin
            exp_q.push_back(marker(3'b010, m_seq, m_hbcnt));
            m_seq++;
            hb_wrote = 1;
        end
        expire = (m_tick == HB - 1);
        m_tick = expire ? 0 : m_tick + 1;
        if (expire) m_hbcnt++;
        m_pend = (m_pend && !hb_wrote) || expire;
        exp_dc = m_drops;
        exp_dropping = (m_held.size() > 0) || (m_drops > 0);
    endtask

    // Monitor: every presented write must match the oldest expected record
    always @(negedge clock) begin
        if (write_clock_enable) begin
            if (exp_q.size() == 0) chk("spurious_write", write_clock_enable, 1'b0);
            else chk("write_data", write_data, exp_q.pop_front());
            last_write = write_data;
        end
    end

    task automatic cyc(input bit en, input bit full, input logic [47:0] d);
        @(negedge clock);
        chk("drop_count", drop_count, exp_dc);
        chk("dropping", dropping, exp_dropping);
        if (after_reset) begin
            chk("reset_wce", write_clock_enable, 1'b0);
            chk("reset_data", write_data, 48'h0);
            after_reset = 1'b0;
        end
        #1;
        reset = 1'b0; lpc_enable = en; buffer_full = full; lpc_data = d;
        model_step(en, full, d);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #1;
        reset = 1'b1; lpc_enable = 1'b0; buffer_full = 1'b0; lpc_data = '0;
        model_reset();
        after_reset = 1'b1;
    endtask

    function automatic logic [47:0] rnd48();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[47:0];
    endfunction

    initial begin
        do_reset();
        cyc(1, 0, 48'h0000_0080_3402);
        cyc(0, 1, '0);
        chk("basic_write", last_write, 48'h0000_0080_3402);

        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 1, rnd48());
        cyc(0, 0, '0);
        cyc(0, 1, '0);
        chk("drop_marker_3", last_write, 48'h0000_0003_002F);

        do_reset();
        cyc(1, 1, rnd48());
        cyc(1, 0, 48'h1234_5678_9ABC);
        cyc(0, 0, '0);
        cyc(0, 1, '0);
        chk("held_record", last_write, 48'h1234_5678_9ABC);
        cyc(0, 1, '0);

        do_reset();
        for (int i = 0; i < 60; i++) cyc(0, 0, '0);
        for (int i = 0; i < 40; i++) cyc(i % 16 == 0, 0, rnd48());

        do_reset();
        for (int i = 0; i < 70000; i++) cyc(1, 1, '0);
        cyc(0, 0, '0);
        cyc(0, 1, '0);
        chk("sat_payload", last_write[47:16], 32'h0000_FFFF);

        do_reset();
        cyc(1, 1, rnd48());
        cyc(1, 0, rnd48());
        cyc(0, 1, '0);
        do_reset();
        for (int i = 0; i < 4; i++) cyc(0, 1, '0);

        do_reset();
        for (int i = 0; i < 4000; i++) begin
            int fp;
            fp = ((i / 200) % 2 == 0) ? 3 : 60;
            cyc(($urandom % 100) < 55, ($urandom % 100) < fp, rnd48());
        end

        for (int i = 0; i < 3; i++) cyc(0, 1, '0);
        chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
